// File: rtl/prog_ins_memory.sv
// Loadable instruction memory: streaming valid/ready loader plus a
// one-cycle-latency fetch port feeding the decoder.
module prog_ins_memory #(
    parameter int unsigned WORD_SIZE  = 8,
    parameter int unsigned NUM_INS    = 16,
    parameter int unsigned INDEX_SIZE = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_start,
    input  logic                  load_valid,
    input  logic                  load_last,
    input  logic [WORD_SIZE-1:0]  load_data,
    output logic                  load_ready,
    output logic                  load_done,
    output logic [INDEX_SIZE:0]   load_count,
    input  logic                  fetch_req,
    input  logic [INDEX_SIZE-1:0] prog_count,
    output logic [WORD_SIZE-1:0]  ins_val,
    output logic                  ins_valid,
    output logic                  busy
);

    localparam int unsigned CNT_W = INDEX_SIZE + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [INDEX_SIZE-1:0]   wr_ptr;
    logic [INDEX_SIZE-1:0]   wr_ptr_next;
    logic [CNT_W-1:0]        count_next;
    logic                    done_next;
    logic                    ready_next;
    logic                    busy_next;
    logic [WORD_SIZE-1:0]    ins_val_next;
    logic                    ins_valid_next;
    logic                    mem_we;

    logic [WORD_SIZE-1:0]    mem [NUM_INS];

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            load_count <= '0;
            load_done  <= 1'b0;
            load_ready <= 1'b0;
            busy       <= 1'b0;
            ins_val    <= '0;
            ins_valid  <= 1'b0;
        end else begin
            state      <= state_next;
            wr_ptr     <= wr_ptr_next;
            load_count <= count_next;
            load_done  <= done_next;
            load_ready <= ready_next;
            busy       <= busy_next;
            ins_val    <= ins_val_next;
            ins_valid  <= ins_valid_next;
        end
    end

    // Instruction array; cleared to NOP on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_INS); i++) begin
                mem[i] <= '0;
            end
        end else if (mem_we) begin
            mem[wr_ptr] <= load_data;
        end
    end

    // Next-state, load accounting and fetch response
    always_comb begin
        state_next     = state;
        wr_ptr_next    = wr_ptr;
        count_next     = load_count;
        done_next      = 1'b0;
        ins_val_next   = ins_val;
        ins_valid_next = 1'b0;
        mem_we         = 1'b0;

        unique case (state)
            IDLE: begin
                if (load_start) begin
                    state_next  = LOAD;
                    wr_ptr_next = '0;
                    count_next  = '0;
                end
            end
            LOAD: begin
                if (load_start) begin
                    // restart: rewind pointer, keep array contents
                    wr_ptr_next = '0;
                    count_next  = '0;
                end else if (load_valid && load_ready) begin
                    mem_we      = 1'b1;
                    wr_ptr_next = wr_ptr + INDEX_SIZE'(1);
                    count_next  = (load_count < CNT_W'(NUM_INS)) ?
                                  load_count + CNT_W'(1) : load_count;
                    if (wr_ptr == INDEX_SIZE'(NUM_INS - 1) || load_last) begin
                        state_next = READY;
                        done_next  = 1'b1;
                    end
                end
            end
            READY: begin
                if (load_start) begin
                    // load wins over a same-cycle fetch
                    state_next  = LOAD;
                    wr_ptr_next = '0;
                    count_next  = '0;
                end else if (fetch_req) begin
                    ins_valid_next = 1'b1;
                    // words beyond the last load read back as NOP
                    ins_val_next   = ({1'b0, prog_count} < load_count) ?
                                     mem[prog_count] : '0;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        ready_next = (state_next == LOAD);
        busy_next  = (state_next == LOAD);
    end

endmodule

// File: tb/tb_prog_ins_memory.sv
// Directed bench for prog_ins_memory with a fetch scoreboard and memory model.
module tb_prog_ins_memory;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_start = 1'b0;
    logic        load_valid = 1'b0;
    logic        load_last = 1'b0;
    logic [7:0]  load_data = '0;
    logic        load_ready;
    logic        load_done;
    logic [4:0]  load_count;
    logic        fetch_req = 1'b0;
    logic [3:0]  prog_count = '0;
    logic [7:0]  ins_val;
    logic        ins_valid;
    logic        busy;

    typedef struct packed {
        logic       valid;
        logic [7:0] val;
    } fetch_exp_t;

    fetch_exp_t  sb_q[$];
    logic [7:0]  model_mem [16];
    logic [7:0]  load_buf [16];
    int          model_count;
    logic [7:0]  model_ins;
    int          n_cmp = 0;
    int          n_err = 0;

    prog_ins_memory #(
        .WORD_SIZE (8),
        .NUM_INS   (16),
        .INDEX_SIZE(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load_start(load_start),
        .load_valid(load_valid),
        .load_last (load_last),
        .load_data (load_data),
        .load_ready(load_ready),
        .load_done (load_done),
        .load_count(load_count),
        .fetch_req (fetch_req),
        .prog_count(prog_count),
        .ins_val   (ins_val),
        .ins_valid (ins_valid),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_fetch(input int a);
        return (a < model_count) ? model_mem[a] : 8'h00;
    endfunction

    // One fetch request; expectation queued at drive, compared at response
    task automatic fetch_one(input int a, input logic exp_valid);
        fetch_exp_t e;
        fetch_exp_t got;
        fetch_req  = 1'b1;
        prog_count = 4'(a);
        if (exp_valid) model_ins = exp_fetch(a);
        e.valid = exp_valid;
        e.val   = model_ins;
        sb_q.push_back(e);
        step();
        got = sb_q.pop_front();
        chk($sformatf("ins_valid@%0d", a), 32'(ins_valid), 32'(got.valid));
        chk($sformatf("ins_val@%0d", a), 32'(ins_val), 32'(got.val));
    endtask

    // Back-to-back fetches, then an idle cycle to check hold behaviour
    task automatic fetch_seq(input int first, input int last);
        for (int a = first; a <= last; a++) fetch_one(a, 1'b1);
        fetch_req = 1'b0;
        step();
        chk("ins_valid_idle", 32'(ins_valid), 32'd0);
        chk("ins_val_hold", 32'(ins_val), 32'(model_ins));
    endtask

    // Load n words from load_buf; throttle gives a valid pattern 1,0,0,...
    task automatic do_load(input int n, input logic use_last, input logic throttle);
        int  i;
        int  c;
        logic v;
        logic fin;
        load_start = 1'b1;
        load_valid = 1'b0;
        step();
        load_start = 1'b0;
        model_count = 0;
        chk("busy_load", 32'(busy), 32'd1);
        chk("ready_load", 32'(load_ready), 32'd1);
        chk("count_start", 32'(load_count), 32'd0);
        i = 0;
        c = 0;
        while (i < n) begin
            v = !throttle || (c % 3 == 0);
            load_valid = v;
            load_data  = load_buf[i];
            // a stray load_last on idle cycles must be ignored
            load_last  = v ? (use_last && (i == n - 1)) : 1'b1;
            step();
            if (v) begin
                fin = (i == n - 1);
                model_mem[i] = load_buf[i];
                model_count++;
                chk("load_count", 32'(load_count), 32'(model_count));
                chk("load_done", 32'(load_done), 32'(fin));
                chk("load_ready", 32'(load_ready), 32'(!fin));
                i++;
            end else begin
                chk("done_idle", 32'(load_done), 32'd0);
                chk("ready_idle", 32'(load_ready), 32'd1);
            end
            c++;
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        step();
        chk("done_pulse", 32'(load_done), 32'd0);
        chk("busy_ready", 32'(busy), 32'd0);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 16; k++) model_mem[k] = 8'h00;
        model_count = 0;
        model_ins   = 8'h00;
    endtask

    initial begin
        model_reset();

        // Reset values
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("rst_ins_val", 32'(ins_val), 32'd0);
        chk("rst_ins_valid", 32'(ins_valid), 32'd0);
        chk("rst_ready", 32'(load_ready), 32'd0);
        chk("rst_done", 32'(load_done), 32'd0);
        chk("rst_count", 32'(load_count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // Fetch ignored in IDLE and in LOAD
        fetch_one(5, 1'b0);
        fetch_req  = 1'b0;
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        fetch_one(5, 1'b0);
        chk("busy_in_load", 32'(busy), 32'd1);
        fetch_req = 1'b0;

        // Full load 0..15 (restarts the pending load), then fetch all
        for (int k = 0; k < 16; k++) load_buf[k] = 8'(k);
        do_load(16, 1'b0, 1'b0);
        chk("count_full", 32'(load_count), 32'd16);
        fetch_seq(0, 15);

        // load_start beats fetch_req in READY
        load_start = 1'b1;
        fetch_req  = 1'b1;
        prog_count = 4'd3;
        step();
        load_start = 1'b0;
        fetch_req  = 1'b0;
        model_count = 0;
        chk("prio_valid", 32'(ins_valid), 32'd0);
        chk("prio_busy", 32'(busy), 32'd1);
        chk("prio_hold", 32'(ins_val), 32'(model_ins));

        // Early-terminated load of three words
        load_buf[0] = 8'hD8;
        load_buf[1] = 8'h51;
        load_buf[2] = 8'hD5;
        do_load(3, 1'b1, 1'b0);
        chk("count_early", 32'(load_count), 32'd3);
        fetch_one(2, 1'b1);
        chk("early_at2", 32'(ins_val), 32'hD5);
        fetch_one(3, 1'b1);
        chk("early_at3", 32'(ins_val), 32'h00);
        fetch_seq(0, 15);

        // Throttled full load
        for (int k = 0; k < 16; k++) load_buf[k] = 8'(k * 7 + 60);
        do_load(16, 1'b0, 1'b1);
        fetch_seq(0, 15);

        // Restart mid-load
        load_start = 1'b1;
        step();
        load_start  = 1'b0;
        model_count = 0;
        load_valid  = 1'b1;
        load_data   = 8'hAA;
        step();
        model_mem[0] = 8'hAA;
        model_count  = 1;
        load_data    = 8'hBB;
        step();
        model_mem[1] = 8'hBB;
        model_count  = 2;
        chk("rs_count2", 32'(load_count), 32'd2);
        load_start = 1'b1;
        load_data  = 8'hCC;
        step();
        load_start  = 1'b0;
        model_count = 0;
        chk("rs_count0", 32'(load_count), 32'd0);
        chk("rs_busy", 32'(busy), 32'd1);
        chk("rs_ready", 32'(load_ready), 32'd1);
        load_data = 8'h11;
        load_last = 1'b1;
        step();
        model_mem[0] = 8'h11;
        model_count  = 1;
        load_valid   = 1'b0;
        load_last    = 1'b0;
        chk("rs_done", 32'(load_done), 32'd1);
        chk("rs_count1", 32'(load_count), 32'd1);
        step();
        chk("rs_done_pulse", 32'(load_done), 32'd0);
        fetch_seq(0, 1);

        // Reset in the middle of a load
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            load_valid = 1'b1;
            load_data  = 8'(8'hE0 + k);
            step();
        end
        load_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_reset();
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_ready", 32'(load_ready), 32'd0);
        chk("mrst_count", 32'(load_count), 32'd0);
        chk("mrst_valid", 32'(ins_valid), 32'd0);
        chk("mrst_ins", 32'(ins_val), 32'd0);
        fetch_one(0, 1'b0);
        fetch_req = 1'b0;
        for (int k = 0; k < 16; k++) load_buf[k] = 8'(k);
        do_load(16, 1'b0, 1'b0);
        chk("count_full2", 32'(load_count), 32'd16);
        fetch_seq(0, 15);

        if (sb_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL scoreboard_drain: observed %0d entries expected 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
